// File: rtl/ram_slot_pkg.sv
// ram_slot_pkg: shared constants for the DRAM slot arbiter and its refresh timer.
// Grant vectors are indexed by the GNT_* constants below.
package ram_slot_pkg;

  localparam logic [1:0] GNT_VID = 2'd0;
  localparam logic [1:0] GNT_SND = 2'd1;
  localparam logic [1:0] GNT_REF = 2'd2;
  localparam logic [1:0] GNT_CPU = 2'd3;

  localparam int NUM_GNT = 4;
  localparam int PHASE_W = 2;

  localparam int REFRESH_INTERVAL_DEF = 64;
  localparam int REF_MAX_PENDING_DEF  = 3;

  // One-hot grant vector for a single owner index.
  function automatic logic [NUM_GNT-1:0] gnt_onehot(input logic [1:0] idx);
    logic [NUM_GNT-1:0] base;
    base = 4'b0001;
    return base << idx;
  endfunction

endpackage

// File: rtl/ram_refresh_timer.sv
// ram_refresh_timer: counts shifter slots and keeps a saturating backlog of
// refresh requests. A wrap of the slot counter adds one to the backlog, a served
// refresh slot removes one; if both land on the same edge the backlog holds.
module ram_refresh_timer
  import ram_slot_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int REF_MAX_PENDING  = REF_MAX_PENDING_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slot_tick,
  input  logic       ref_served,
  output logic [1:0] ref_pending
);

  localparam logic [7:0] WRAP_AT  = 8'(REFRESH_INTERVAL - 1);
  localparam logic [1:0] PEND_MAX = 2'(REF_MAX_PENDING);

  logic [7:0] slot_cnt_r;
  logic [1:0] pend_r;
  logic       wrap_s;

  assign wrap_s      = slot_tick & (slot_cnt_r == WRAP_AT);
  assign ref_pending = pend_r;

  // Shifter-slot counter, wrapping once per refresh interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r <= 8'd0;
    end else if (wrap_s) begin
      slot_cnt_r <= 8'd0;
    end else if (slot_tick) begin
      slot_cnt_r <= slot_cnt_r + 8'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r;
    end
  end

  // Refresh backlog: saturating up on wrap, down on a served refresh slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 2'd0;
    end else begin
      case ({wrap_s, ref_served})
        2'b10: pend_r <= (pend_r == PEND_MAX) ? pend_r : pend_r + 2'd1;
        2'b01: pend_r <= (pend_r == 2'd0) ? pend_r : pend_r - 2'd1;
        default: pend_r <= pend_r;
      endcase
    end
  end

endmodule

// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter: splits the DRAM bus into 4-cycle slots, alternating
// shifter slots (video / sound / refresh) with CPU slots. The winner for a slot
// is chosen on the edge that closes the previous slot and held for all 4 phases.
// Optional feature macro: RAM_SLOT_CPU_FILL_EN (idle shifter slots go to the CPU).
module ram_slot_arbiter
  import ram_slot_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int REF_MAX_PENDING  = REF_MAX_PENDING_DEF
) (
  input  logic               clk,
  input  logic               por,
  input  logic               vid_req,
  input  logic               snd_req,
  input  logic               sndon,
  input  logic               cpu_req,
  output logic               gnt_vid,
  output logic               gnt_snd,
  output logic               gnt_ref,
  output logic               gnt_cpu,
  output logic               vid_ack,
  output logic               snd_ack,
  output logic               cpu_ack,
  output logic               ram_cyc,
  output logic [PHASE_W-1:0] phase,
  output logic               slot_odd,
  output logic [1:0]         ref_pending
);

  localparam logic [1:0] REF_MAX_P = 2'(REF_MAX_PENDING);

  logic [PHASE_W-1:0] phase_r;
  logic               slot_odd_r;
  logic [NUM_GNT-1:0] gnt_r;
  logic [NUM_GNT-1:0] gnt_next_s;
  logic               vid_ack_r;
  logic               snd_ack_r;
  logic               cpu_ack_r;
  logic               ram_cyc_r;
  logic               slot_end_s;
  logic               shifter_tick_s;
  logic               ref_served_s;
  logic [1:0]         ref_pending_s;
  logic               ref_urgent_s;
  logic               ref_want_s;
  logic               snd_want_s;

  assign slot_end_s     = (phase_r == 2'd3);
  assign shifter_tick_s = slot_end_s & ~slot_odd_r;
  assign ref_served_s   = slot_end_s & gnt_r[GNT_REF];
  assign ref_urgent_s   = (ref_pending_s == REF_MAX_P);
  assign ref_want_s     = (ref_pending_s != 2'd0);
  assign snd_want_s     = snd_req & sndon;

  ram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .REF_MAX_PENDING  (REF_MAX_PENDING)
  ) u_refresh (
    .clk         (clk),
    .rst         (por),
    .slot_tick   (shifter_tick_s),
    .ref_served  (ref_served_s),
    .ref_pending (ref_pending_s)
  );

  // Winner selection for the next slot; grants only change at a slot boundary.
  always_comb begin
    gnt_next_s = gnt_r;
    if (slot_end_s) begin
      if (slot_odd_r) begin
        // Next slot is a shifter slot.
        if (ref_urgent_s) begin
          gnt_next_s = gnt_onehot(GNT_REF);
        end else if (vid_req) begin
          gnt_next_s = gnt_onehot(GNT_VID);
        end else if (snd_want_s) begin
          gnt_next_s = gnt_onehot(GNT_SND);
        end else if (ref_want_s) begin
          gnt_next_s = gnt_onehot(GNT_REF);
`ifdef RAM_SLOT_CPU_FILL_EN
        end else if (cpu_req) begin
          gnt_next_s = gnt_onehot(GNT_CPU);
`endif
        end else begin
          gnt_next_s = 4'b0000;
        end
      end else begin
        // Next slot is a CPU slot.
        if (cpu_req) begin
          gnt_next_s = gnt_onehot(GNT_CPU);
        end else begin
          gnt_next_s = 4'b0000;
        end
      end
    end else begin
      gnt_next_s = gnt_r;
    end
  end

  // Phase/slot tracking, grant register, and the registered acks and RAS window.
  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      phase_r    <= 2'd0;
      slot_odd_r <= 1'b0;
      gnt_r      <= 4'b0000;
      vid_ack_r  <= 1'b0;
      snd_ack_r  <= 1'b0;
      cpu_ack_r  <= 1'b0;
      ram_cyc_r  <= 1'b0;
    end else begin
      phase_r    <= phase_r + 2'd1;
      slot_odd_r <= slot_end_s ? ~slot_odd_r : slot_odd_r;
      gnt_r      <= gnt_next_s;
      // Acks become visible in phase 3, the last cycle of the granted slot.
      vid_ack_r  <= gnt_r[GNT_VID] & (phase_r == 2'd2);
      snd_ack_r  <= gnt_r[GNT_SND] & (phase_r == 2'd2);
      cpu_ack_r  <= gnt_r[GNT_CPU] & (phase_r == 2'd2);
      // RAS window covers phases 1 and 2 of a granted slot.
      ram_cyc_r  <= (|gnt_r) & ((phase_r == 2'd0) | (phase_r == 2'd1));
    end
  end

  assign gnt_vid     = gnt_r[GNT_VID];
  assign gnt_snd     = gnt_r[GNT_SND];
  assign gnt_ref     = gnt_r[GNT_REF];
  assign gnt_cpu     = gnt_r[GNT_CPU];
  assign vid_ack     = vid_ack_r;
  assign snd_ack     = snd_ack_r;
  assign cpu_ack     = cpu_ack_r;
  assign ram_cyc     = ram_cyc_r;
  assign phase       = phase_r;
  assign slot_odd    = slot_odd_r;
  assign ref_pending = ref_pending_s;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb_ram_slot_arbiter: directed scenarios plus a randomized run, every cycle
// compared with a slot-level reference model kept in the bench.
// Honours RAM_SLOT_CPU_FILL_EN when the bench is built with it.
module tb_ram_slot_arbiter;

  localparam int RI   = 64;
  localparam int MAXP = 3;
  localparam int GVID = 0;
  localparam int GSND = 1;
  localparam int GREF = 2;
  localparam int GCPU = 3;

  logic       clk = 1'b0;
  logic       por = 1'b1;
  logic       vid_req = 1'b0, snd_req = 1'b0, sndon = 1'b0, cpu_req = 1'b0;
  logic       gnt_vid, gnt_snd, gnt_ref, gnt_cpu;
  logic       vid_ack, snd_ack, cpu_ack, ram_cyc, slot_odd;
  logic [1:0] phase, ref_pending;

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since reset release, current slot owner
  // (-1 = idle), refresh backlog and number of completed shifter slots.
  int m_t = 0;
  int m_owner = -1;
  int m_pending = 0;
  int m_shift_done = 0;

  ram_slot_arbiter dut (
    .clk(clk), .por(por), .vid_req(vid_req), .snd_req(snd_req), .sndon(sndon),
    .cpu_req(cpu_req), .gnt_vid(gnt_vid), .gnt_snd(gnt_snd), .gnt_ref(gnt_ref),
    .gnt_cpu(gnt_cpu), .vid_ack(vid_ack), .snd_ack(snd_ack), .cpu_ack(cpu_ack),
    .ram_cyc(ram_cyc), .phase(phase), .slot_odd(slot_odd), .ref_pending(ref_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // Shifter-slot winner from the priority rules.
  function automatic int pick_shifter();
    if (m_pending == MAXP) return GREF;
    if (vid_req) return GVID;
    if (snd_req && sndon) return GSND;
    if (m_pending > 0) return GREF;
`ifdef RAM_SLOT_CPU_FILL_EN
    if (cpu_req) return GCPU;
`endif
    return -1;
  endfunction

  task automatic check_all();
    int ph;
    logic [3:0] one4;
    logic [3:0] exp_gnt;
    logic [2:0] exp_ack;
    one4 = 4'b0001;
    ph = m_t % 4;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (one4 << m_owner);
    exp_ack = 3'b000;
    if (ph == 3) exp_ack = {exp_gnt[GCPU], exp_gnt[GSND], exp_gnt[GVID]};
    chk("phase", 8'(phase), 8'(ph));
    chk("slot_odd", 8'(slot_odd), 8'((m_t / 4) % 2));
    chk("grants", 8'({gnt_cpu, gnt_ref, gnt_snd, gnt_vid}), 8'(exp_gnt));
    chk("acks", 8'({cpu_ack, snd_ack, vid_ack}), 8'(exp_ack));
    chk("ram_cyc", 8'(ram_cyc), 8'((m_owner >= 0) && (ph == 1 || ph == 2)));
    chk("ref_pending", 8'(ref_pending), 8'(m_pending));
  endtask

  // Advance one clock: update the model with the inputs the DUT samples, then check.
  task automatic tick();
    int ph, odd, nxt;
    logic served, wrap;
    ph = m_t % 4;
    odd = (m_t / 4) % 2;
    if (ph == 3) begin
      served = (m_owner == GREF);
      wrap = 1'b0;
      if (odd == 0) begin
        m_shift_done++;
        wrap = ((m_shift_done % RI) == 0);
      end
      if (odd == 1) nxt = pick_shifter();
      else nxt = cpu_req ? GCPU : -1;
      if (wrap && !served) m_pending = (m_pending < MAXP) ? m_pending + 1 : MAXP;
      else if (served && !wrap) m_pending = m_pending - 1;
      m_owner = nxt;
    end
    m_t++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    while (m_t < target) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    por = 1'b1;
    {vid_req, snd_req, sndon, cpu_req} = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 8'({gnt_cpu, gnt_ref, gnt_snd, gnt_vid, cpu_ack, snd_ack, vid_ack, ram_cyc}), 8'h00);
    chk("rst_phase", 8'({phase, slot_odd, ref_pending}), 8'h00);
    por = 1'b0;
    m_t = 0; m_owner = -1; m_pending = 0; m_shift_done = 0;
  endtask

  initial begin
    int cnt;
    int guard;

    // 1. Reset, then idle: first refresh after 64 shifter slots.
    do_reset();
    run_to(508);
    chk("idle_pending_1", 8'(ref_pending), 8'd1);
    run_to(512);
    for (int i = 0; i < 4; i++) begin
      chk("idle_gnt_ref", 8'(gnt_ref), 8'd1);
      tick();
    end
    chk("idle_pending_0", 8'(ref_pending), 8'd0);

    // 2. CPU held high: ack rate depends on the fill option.
    do_reset();
    cpu_req = 1'b1;
    run_to(4);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (cpu_ack === 1'b1) cnt++;
    end
`ifdef RAM_SLOT_CPU_FILL_EN
    chk("cpu_ack_rate", 8'(cnt), 8'd8);
`else
    chk("cpu_ack_rate", 8'(cnt), 8'd4);
`endif

    // 3. Video and sound both pending: video wins until refresh turns urgent.
    do_reset();
    {vid_req, snd_req, sndon} = 3'b111;
    cnt = 0;
    guard = 0;
    while (ref_pending !== 2'd3 && guard < 2000) begin
      tick();
      if (snd_ack === 1'b1) cnt++;
      guard++;
    end
    chk("urgent_reached", 8'(guard < 2000), 8'd1);
    chk("snd_ack_never", 8'(cnt), 8'd0);
    repeat (4) tick();
    chk("urgent_gnt_ref", 8'(gnt_ref), 8'd1);
    chk("urgent_no_vid", 8'(gnt_vid), 8'd0);

    // 4. Sound masked by sndon, then enabled.
    do_reset();
    snd_req = 1'b1;
    cnt = 0;
    while (m_t < 16) begin
      tick();
      if (gnt_snd === 1'b1) cnt++;
    end
    chk("snd_masked", 8'(cnt), 8'd0);
    sndon = 1'b1;
    run_to(24);
    chk("snd_granted", 8'(gnt_snd), 8'd1);
    run_to(27);
    chk("snd_ack_ph3", 8'(snd_ack), 8'd1);

    // 5. Reset during phase 2 of a video slot.
    do_reset();
    vid_req = 1'b1;
    run_to(10);
    chk("pre_abort_gnt_vid", 8'(gnt_vid), 8'd1);
    #2;
    por = 1'b1;
    #1;
    chk("abort_grants", 8'({gnt_cpu, gnt_ref, gnt_snd, gnt_vid}), 8'h0);
    chk("abort_ram_cyc", 8'(ram_cyc), 8'd0);
    @(posedge clk);
    #1;
    chk("abort_no_vid_ack", 8'(vid_ack), 8'd0);
    @(negedge clk);
    por = 1'b0;
    #1;
    chk("abort_phase", 8'({phase, slot_odd}), 8'h0);
    m_t = 0; m_owner = -1; m_pending = 0; m_shift_done = 0;
    vid_req = 1'b0;
    repeat (8) tick();

    // 6. Timer wrap on the same edge as a served refresh at backlog 2.
    do_reset();
    vid_req = 1'b1;
    run_to(1520);
    vid_req = 1'b0;
    run_to(1528);
    chk("coinc_gnt_ref", 8'(gnt_ref), 8'd1);
    chk("coinc_pending_before", 8'(ref_pending), 8'd2);
    run_to(1532);
    chk("coinc_pending_after", 8'(ref_pending), 8'd2);

    // 7. Randomized requests against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      {vid_req, snd_req, sndon, cpu_req} = 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
